// File: rtl/vga_timing_pkg.sv
// VGA 640x480@60 timing constants and shared types.
// Default geometry, counter width, sync bundle and RGB444 pixel.
package vga_timing_pkg;

  localparam int unsigned CNT_W = 10;

  localparam int unsigned H_VIS_DEF  = 640;
  localparam int unsigned H_FP_DEF   = 16;
  localparam int unsigned H_SYNC_DEF = 96;
  localparam int unsigned H_BP_DEF   = 48;
  localparam int unsigned V_VIS_DEF  = 480;
  localparam int unsigned V_FP_DEF   = 10;
  localparam int unsigned V_SYNC_DEF = 2;
  localparam int unsigned V_BP_DEF   = 33;

  localparam int unsigned H_TOT_DEF =
    H_VIS_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int unsigned V_TOT_DEF =
    V_VIS_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int unsigned HS_START_DEF = H_VIS_DEF + H_FP_DEF;
  localparam int unsigned HS_END_DEF   = HS_START_DEF + H_SYNC_DEF - 1;
  localparam int unsigned VS_START_DEF = V_VIS_DEF + V_FP_DEF;
  localparam int unsigned VS_END_DEF   = VS_START_DEF + V_SYNC_DEF - 1;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  typedef struct packed {
    logic valid;
    logic hs;
    logic vs;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{valid: 1'b0, hs: 1'b1, vs: 1'b1};

endpackage

// File: rtl/vga_sync_delay.sv
// Enabled shift line of DEPTH words with a synchronous reset value.
// DEPTH=0 degenerates to a wire.
module vga_sync_delay #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 3,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_pass
    logic unused_ok;
    assign unused_ok = ^{clk, rst, en};
    assign q = d;
  end else begin : g_line
    logic [WIDTH-1:0] line [DEPTH];

    // shift one place per enable, idle fill on reset
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < int'(DEPTH); i++)
          line[i] <= RST_VAL;
      end else if (en) begin
        line[0] <= d;
        for (int i = 1; i < int'(DEPTH); i++)
          line[i] <= line[i-1];
      end
    end

    assign q = line[DEPTH-1];
  end

endmodule

// File: rtl/vga_scan_ctrl.sv
// Scan-timing master: pixel divider, h/v counters, sync decode,
// latency-matched sync delay and registered VGA pins.
module vga_scan_ctrl
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VIS   = H_VIS_DEF,
  parameter int unsigned H_FP    = H_FP_DEF,
  parameter int unsigned H_SYNC  = H_SYNC_DEF,
  parameter int unsigned H_BP    = H_BP_DEF,
  parameter int unsigned V_VIS   = V_VIS_DEF,
  parameter int unsigned V_FP    = V_FP_DEF,
  parameter int unsigned V_SYNC  = V_SYNC_DEF,
  parameter int unsigned V_BP    = V_BP_DEF,
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned PIX_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [11:0]     pixel_in,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic            valid,
  output logic            pix_tick,
  output logic            frame_start,
  output logic            hsync,
  output logic            vsync,
  output logic [3:0]      vga_r,
  output logic [3:0]      vga_g,
  output logic [3:0]      vga_b
);

  localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  localparam cnt_t H_LAST = cnt_t'(H_TOT - 1);
  localparam cnt_t V_LAST = cnt_t'(V_TOT - 1);
  localparam cnt_t H_VISC = cnt_t'(H_VIS);
  localparam cnt_t V_VISC = cnt_t'(V_VIS);
  localparam cnt_t HS_LO  = cnt_t'(H_VIS + H_FP);
  localparam cnt_t HS_HI  = cnt_t'(H_VIS + H_FP + H_SYNC - 1);
  localparam cnt_t VS_LO  = cnt_t'(V_VIS + V_FP);
  localparam cnt_t VS_HI  = cnt_t'(V_VIS + V_FP + V_SYNC - 1);

  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

  if (H_TOT > 1023 || V_TOT > 1023 ||
      CLK_DIV < 1 || CLK_DIV > 16 ||
      PIX_LAT < 1 || PIX_LAT > 4) begin : g_bad_param
    $fatal(1, "vga_scan_ctrl: timing parameters out of range");
  end

  logic [3:0] div;
  logic       h_end;
  logic       v_end;
  sync_t      st0;
  sync_t      st_out;
  rgb444_t    rgb;

  // clk divider producing one pixel tick every CLK_DIV clocks
  always_ff @(posedge clk) begin
    if (rst)
      div <= '0;
    else if (div == DIV_LAST)
      div <= '0;
    else
      div <= div + 4'd1;
  end

  assign pix_tick = ~rst & (div == DIV_LAST);

  assign h_end = (h_cnt == H_LAST);
  assign v_end = (v_cnt == V_LAST);

  // raster counters, advancing on the pixel tick
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_tick) begin
      if (h_end) begin
        h_cnt <= '0;
        v_cnt <= v_end ? '0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  assign frame_start = pix_tick & h_end & v_end;

  assign st0.valid = (h_cnt < H_VISC) && (v_cnt < V_VISC);
  assign st0.hs    = ~((h_cnt >= HS_LO) && (h_cnt <= HS_HI));
  assign st0.vs    = ~((v_cnt >= VS_LO) && (v_cnt <= VS_HI));
  assign valid     = st0.valid;

  vga_sync_delay #(
    .DEPTH  (PIX_LAT - 1),
    .WIDTH  (3),
    .RST_VAL(SYNC_IDLE)
  ) u_sync_delay (
    .clk(clk),
    .rst(rst),
    .en (pix_tick),
    .d  (st0),
    .q  (st_out)
  );

  // pin register: syncs and blanked colour from the delayed decode
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync <= 1'b1;
      vsync <= 1'b1;
      rgb   <= '0;
    end else if (pix_tick) begin
      hsync <= st_out.hs;
      vsync <= st_out.vs;
      rgb   <= st_out.valid ? rgb444_t'(pixel_in) : '0;
    end
  end

  assign vga_r = rgb.r;
  assign vga_g = rgb.g;
  assign vga_b = rgb.b;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Scoreboard bench for vga_scan_ctrl: default timing (div 4, lat 1)
// and a shrunken raster (div 2, lat 3) so whole frames fit.
module tb_vga_scan_ctrl;

  typedef struct packed {
    int hv; int hf; int hs; int ht;
    int vv; int vf; int vs; int vt;
    int d;  int lat;
  } cfg_t;

  localparam cfg_t CA = '{hv: 640, hf: 16, hs: 96, ht: 800,
                          vv: 480, vf: 10, vs: 2, vt: 525,
                          d: 4, lat: 1};
  localparam cfg_t CB = '{hv: 8, hf: 2, hs: 3, ht: 15,
                          vv: 4, vf: 2, vs: 2, vt: 10,
                          d: 2, lat: 3};
  localparam int B_FFF_TICKS = 750;

  logic clk;
  logic rst;
  logic [11:0] pix_a, pix_b;
  logic [9:0] h_a, v_a, h_b, v_b;
  logic val_a, tick_a, fs_a, hs_a, vs_a;
  logic val_b, tick_b, fs_b, hs_b, vs_b;
  logic [3:0] r_a, g_a, b_a, r_b, g_b, b_b;

  int checks;
  int failures;
  logic [13:0] qa[$];
  logic [13:0] qb[$];
  int hs_run_a, hs_run_b, vs_run_b, fb_cnt;

  vga_scan_ctrl #(
    .CLK_DIV(4), .PIX_LAT(1)
  ) u_a (
    .clk(clk), .rst(rst), .pixel_in(pix_a),
    .h_cnt(h_a), .v_cnt(v_a), .valid(val_a),
    .pix_tick(tick_a), .frame_start(fs_a),
    .hsync(hs_a), .vsync(vs_a),
    .vga_r(r_a), .vga_g(g_a), .vga_b(b_a)
  );

  vga_scan_ctrl #(
    .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VIS(4), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .CLK_DIV(2), .PIX_LAT(3)
  ) u_b (
    .clk(clk), .rst(rst), .pixel_in(pix_b),
    .h_cnt(h_b), .v_cnt(v_b), .valid(val_b),
    .pix_tick(tick_b), .frame_start(fs_b),
    .hsync(hs_b), .vsync(vs_b),
    .vga_r(r_b), .vga_g(g_b), .vga_b(b_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d",
               name, $time, act, exp);
    end
  endtask

  function automatic logic [11:0] pixv(input cfg_t c, input int m,
                                       input bit fff);
    if (m < 0) return 12'h000;
    return fff ? 12'hFFF : 12'(m % c.ht);
  endfunction

  function automatic logic [13:0] pins(input cfg_t c, input int k,
                                       input bit fff);
    int m, h, v;
    logic hs, vs;
    logic [11:0] rgb;
    m = k - c.lat;
    if (m < 0) return {2'b11, 12'h000};
    h = m % c.ht;
    v = (m / c.ht) % c.vt;
    hs = !(h >= c.hv + c.hf && h < c.hv + c.hf + c.hs);
    vs = !(v >= c.vv + c.vf && v < c.vv + c.vf + c.vs);
    rgb = (h < c.hv && v < c.vv) ? pixv(c, m, fff) : 12'h000;
    return {hs, vs, rgb};
  endfunction

  task automatic cycle_chk(input cfg_t c, input int cyc,
                           input string tag,
                           input logic [9:0] h, input logic [9:0] v,
                           input logic vl, input logic tk,
                           input logic fs);
    int n, eh, ev;
    bit et;
    n  = cyc / c.d;
    eh = n % c.ht;
    ev = (n / c.ht) % c.vt;
    et = (cyc % c.d) == c.d - 1;
    chk({tag, "_h_cnt"}, int'(h), eh);
    chk({tag, "_v_cnt"}, int'(v), ev);
    chk({tag, "_valid"}, int'(vl), int'(eh < c.hv && ev < c.vv));
    chk({tag, "_pix_tick"}, int'(tk), int'(et));
    chk({tag, "_frame_start"}, int'(fs),
        int'(et && eh == c.ht - 1 && ev == c.vt - 1));
  endtask

  task automatic reset_chk();
    chk("rst_h_a", int'(h_a), 0);
    chk("rst_v_a", int'(v_a), 0);
    chk("rst_tick_a", int'(tick_a), 0);
    chk("rst_fs_a", int'(fs_a), 0);
    chk("rst_pins_a", int'({hs_a, vs_a, r_a, g_a, b_a}), 14'h3000);
    chk("rst_h_b", int'(h_b), 0);
    chk("rst_v_b", int'(v_b), 0);
    chk("rst_tick_b", int'(tick_b), 0);
    chk("rst_fs_b", int'(fs_b), 0);
    chk("rst_pins_b", int'({hs_b, vs_b, r_b, g_b, b_b}), 14'h3000);
  endtask

  task automatic run_phase(input int ncyc);
    int ka, kb;
    fb_cnt = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (c != 0) @(negedge clk);
      rst = 1'b0;
      ka = c / CA.d + 1;
      kb = c / CB.d + 1;
      pix_a = pixv(CA, ka - CA.lat, 1'b0);
      pix_b = pixv(CB, kb - CB.lat, kb < B_FFF_TICKS);
      #1;
      cycle_chk(CA, c, "a", h_a, v_a, val_a, tick_a, fs_a);
      cycle_chk(CB, c, "b", h_b, v_b, val_b, tick_b, fs_b);
      if (c % CA.d == CA.d - 1)
        qa.push_back(pins(CA, ka, 1'b0));
      if (c % CB.d == CB.d - 1)
        qb.push_back(pins(CB, kb, kb < B_FFF_TICKS));
      if (tick_b) fb_cnt++;
      if (fs_b) begin
        chk("frame_ticks_b", fb_cnt, CB.ht * CB.vt);
        fb_cnt = 0;
      end
    end
  endtask

  always @(posedge clk) begin
    if (tick_a) begin
      #1;
      if (qa.size() == 0) begin
        chk("unexpected_tick_a", 1, 0);
      end else begin
        chk("pins_a", int'({hs_a, vs_a, r_a, g_a, b_a}),
            int'(qa.pop_front()));
        if (!hs_a) hs_run_a++;
        else if (hs_run_a != 0) begin
          chk("hsync_low_ticks_a", hs_run_a, CA.hs);
          hs_run_a = 0;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (tick_b) begin
      #1;
      if (qb.size() == 0) begin
        chk("unexpected_tick_b", 1, 0);
      end else begin
        chk("pins_b", int'({hs_b, vs_b, r_b, g_b, b_b}),
            int'(qb.pop_front()));
        if (!hs_b) hs_run_b++;
        else if (hs_run_b != 0) begin
          chk("hsync_low_ticks_b", hs_run_b, CB.hs);
          hs_run_b = 0;
        end
        if (!vs_b) vs_run_b++;
        else if (vs_run_b != 0) begin
          chk("vsync_low_ticks_b", vs_run_b, CB.vs * CB.ht);
          vs_run_b = 0;
        end
      end
    end
  end

  initial begin
    checks = 0;
    failures = 0;
    hs_run_a = 0;
    hs_run_b = 0;
    vs_run_b = 0;
    fb_cnt = 0;
    rst = 1'b1;
    pix_a = '0;
    pix_b = '0;
    repeat (3) begin
      @(negedge clk);
      reset_chk();
    end
    run_phase(4400);
    @(negedge clk);
    rst = 1'b1;
    hs_run_a = 0;
    hs_run_b = 0;
    vs_run_b = 0;
    #1;
    chk("rst_pending_h_a", int'(h_a), 300);
    chk("rst_pending_v_a", int'(v_a), 1);
    chk("rst_gates_tick_a", int'(tick_a), 0);
    @(negedge clk);
    reset_chk();
    run_phase(7000);
    @(negedge clk);
    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
